// File: rtl/ysyx_23060203_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// byte-lane masks and the misalignment rule.
package ysyx_23060203_lsu_pkg;

  localparam logic [2:0] LD_B  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_W  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd4;
  localparam logic [2:0] LD_HU = 3'd5;
  localparam logic [2:0] ST_B  = 3'd0;
  localparam logic [2:0] ST_H  = 3'd1;
  localparam logic [2:0] ST_W  = 3'd2;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  // Halfwords must sit on an even byte, words on a word boundary.
  function automatic logic is_misaligned(input logic [2:0] func, input logic [1:0] off);
    logic half;
    logic word;
    half = (func == LD_H) || (func == LD_HU);
    word = (func == LD_W);
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_23060203_lsu_align.sv
// Combinational byte-lane steering: store mask/data placement, load
// extraction with sign/zero extension, and the misalignment flag.
module ysyx_23060203_lsu_align
  import ysyx_23060203_lsu_pkg::*;
(
  input  logic [2:0]  func,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [4:0]  shamt;
  logic [31:0] ld_sh;

  assign shamt = {off, 3'b000};
  assign wdata = st_data << shamt;
  assign ld_sh = ld_word >> shamt;
  assign misalign = is_misaligned(func, off);

  // Shifts stay 4 lanes wide, so bytes pushed past lane 3 simply fall off.
  always_comb begin
    wmask = MASK_W;
    case (func)
      ST_B:    wmask = MASK_B << off;
      ST_H:    wmask = MASK_H << off;
      default: wmask = MASK_W;
    endcase
  end

  always_comb begin
    rdata = ld_sh;
    case (func)
      LD_B:    rdata = {{24{ld_sh[7]}}, ld_sh[7:0]};
      LD_H:    rdata = {{16{ld_sh[15]}}, ld_sh[15:0]};
      LD_BU:   rdata = {24'd0, ld_sh[7:0]};
      LD_HU:   rdata = {16'd0, ld_sh[15:0]};
      default: rdata = ld_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_23060203_lsu.sv
// Load/store unit: one op at a time from execute to data memory and back.
// Misaligned-access trapping is enabled with YSYX_23060203_LSU_MISALIGN_EN.
//
// state  | meaning
// IDLE   | waiting for an op, in_ready=1
// REQ    | memory request presented until accepted
// RESP   | waiting for read data / write ack
// DONE   | result presented to writeback until accepted
module ysyx_23060203_lsu
  import ysyx_23060203_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic              in_ren,
  input  logic [2:0]        in_func,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_rdata,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [31:0]       mem_resp_rdata
);

  lsu_state_e        state_q, state_d;
  logic              wen_q, wen_d;
  logic [2:0]        func_q, func_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [3:0]        al_wmask;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;
  logic              al_misalign;
  logic              unused_misalign;
  logic              in_misalign;

  ysyx_23060203_lsu_align u_align (
    .func     (func_q),
    .off      (addr_q[1:0]),
    .st_data  (wdata_q),
    .ld_word  (mem_resp_rdata),
    .wmask    (al_wmask),
    .wdata    (al_wdata),
    .rdata    (al_rdata),
    .misalign (al_misalign)
  );

  // The trap decision is taken on the incoming op, not the captured one.
  assign unused_misalign = al_misalign;

`ifdef YSYX_23060203_LSU_MISALIGN_EN
  logic err_q, err_d;

  assign in_misalign = is_misaligned(in_func, in_addr[1:0]);

  always_comb begin
    err_d = err_q;
    if (state_q == S_IDLE && in_valid) begin
      err_d = (in_wen | in_ren) & in_misalign;
    end else if (state_q == S_DONE && out_ready) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign out_err = err_q;
`else
  assign in_misalign = 1'b0;
  assign out_err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    func_d  = func_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          wen_d   = in_wen;
          func_d  = in_func;
          addr_d  = in_addr;
          wdata_d = in_wdata;
          rd_d    = in_rd;
          rdata_d = '0;
          if ((in_wen | in_ren) && !in_misalign) state_d = S_REQ;
          else                                   state_d = S_DONE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_RESP;
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          rdata_d = wen_q ? 32'd0 : al_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      wen_q   <= 1'b0;
      func_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      func_q  <= func_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
    end
  end

  assign in_ready       = (state_q == S_IDLE);
  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_resp_ready = (state_q == S_RESP);
  assign out_valid      = (state_q == S_DONE);

  // Request fields read as zero outside REQ so an idle port is quiet.
  assign mem_req_wen   = mem_req_valid & wen_q;
  assign mem_req_addr  = mem_req_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_req_wdata = mem_req_valid ? al_wdata : 32'd0;
  assign mem_req_wmask = mem_req_valid ? al_wmask : 4'd0;

  assign out_rdata = rdata_q;
  assign out_rd    = rd_q;

endmodule
